// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_pkg
//  Purpose  : Shared constants and the IF/ID bundle type for the fetch stage
//             and decode.
//  Contents : NOP_INSTR - canonical RV32I NOP (addi x0, x0, 0)
//             if_id_t   - {instr, pc, pc4} bundle handed across IF/ID
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } if_id_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Parameterised single-clock queue with synchronous clear.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             clear_i         - synchronous flush (wins over push/pop)
//             push_i, wdata_i - write side (ignored when full)
//             pop_i, rdata_o  - read side; rdata_o shows the head entry
//             full_o, empty_o, count_o - occupancy status
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : RV32I instruction fetch. Owns the PC, issues word fetches over a
//             valid/ready request channel, queues in-order responses and hands
//             {instr, pc, pc+4} to decode. EX redirects flush the queue and
//             discard every response still in flight.
//  Ports    : clk, rst                    - clock, async active-high reset
//             imem_req_valid_o/ready_i    - fetch request handshake
//             imem_req_addr_o             - fetch address (the PC register)
//             imem_rsp_valid_i/data_i     - in-order responses, no backpressure
//             redirect_i, redirect_pc_i   - EX redirect and its target
//             id_valid_o/id_ready_i       - decode handshake
//             id_instr_o/id_pc_o/id_pc4_o - IF/ID bundle (NOP when idle)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc4_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  iq_count;
  logic [CNT_W:0]    credit_used;
  logic              req_fire;
  logic              iq_push, iq_pop, iq_full, iq_empty;
  logic              fl_full, fl_empty;
  logic [XLEN-1:0]   fl_pc;
  logic [2*XLEN-1:0] iq_head;
  if_id_t            if_id;

  // Outstanding requests plus queued instructions never exceed the queue
  // depth, so every accepted response always has a slot waiting for it.
  assign credit_used      = {1'b0, outstanding} + {1'b0, iq_count};
  assign imem_req_valid_o = ~rst & (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;

  assign iq_push = imem_rsp_valid_i & (drop_cnt_q == '0) & ~redirect_i;
  assign iq_pop  = id_valid_o & id_ready_i & ~redirect_i;

  // In-flight PC queue: its occupancy is the outstanding-request count. It is
  // never flushed, since stale responses still arrive and must be paired off.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_inflight (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (imem_rsp_valid_i),
    .rdata_o (fl_pc),
    .full_o  (fl_full),
    .empty_o (fl_empty),
    .count_o (outstanding)
  );

  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_instq (
    .clk     (clk),
    .rst     (rst),
    .clear_i (redirect_i),
    .push_i  (iq_push),
    .wdata_i ({fl_pc, imem_rsp_data_i}),
    .pop_i   (iq_pop),
    .rdata_o (iq_head),
    .full_o  (iq_full),
    .empty_o (iq_empty),
    .count_o (iq_count)
  );

  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      // Responses already marked for dropping are part of 'outstanding', so
      // the new drop count is the in-flight total left after this cycle.
      drop_cnt_d = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid_i);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (imem_rsp_valid_i && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    if_id.instr = NOP_INSTR;
    if_id.pc    = RESET_PC;
    if (!iq_empty) begin
      if_id.instr = iq_head[XLEN-1:0];
      if_id.pc    = iq_head[2*XLEN-1:XLEN];
    end
    if_id.pc4 = if_id.pc + XLEN'(4);
  end

  assign id_valid_o = ~iq_empty;
  assign id_instr_o = if_id.instr;
  assign id_pc_o    = if_id.pc;
  assign id_pc4_o   = if_id.pc4;

  a_iq_no_overflow: assert property (@(posedge clk) disable iff (rst)
    iq_push |-> !iq_full);
  a_inflight_no_overflow: assert property (@(posedge clk) disable iff (rst)
    req_fire |-> !fl_full);
  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid_i |-> !fl_empty);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage: vector tables for the
//             stream and stall timelines, hand sequences for redirect corner
//             cases, then randomized traffic against a program-order model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o, id_ready_i;
  logic [31:0] id_instr_o, id_pc_o, id_pc4_o;

  fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_instr_o       (id_instr_o),
    .id_pc_o          (id_pc_o),
    .id_pc4_o         (id_pc4_o)
  );

  always #5 clk = ~clk;

  // Memory model: accepted requests wait in order until their due cycle.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t memq[$];

  typedef struct {
    bit          idr;
    bit          rv;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] pc;
  } vec_t;

  vec_t stream_tbl[6];
  vec_t stall_tbl[16];

  int          lat = 1;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_chk = 0;
  logic [31:0] exp_pc, exp_fetch;
  bit          prev_redir, prev_stall;
  logic [96:0] prev_bundle;
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_instr, s_pc, s_pc4;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // One clock cycle: sample outputs at the falling edge, check them against
  // the program-order model, then drive this cycle's inputs.
  task automatic step(input bit rdy, input bit idr, input bit redir, input logic [31:0] tgt);
    logic [96:0] bundle;
    logic [31:0] e4;
    bit          fire;
    @(negedge clk);
    s_rv    = imem_req_valid_o;
    s_addr  = imem_req_addr_o;
    s_iv    = id_valid_o;
    s_instr = id_instr_o;
    s_pc    = id_pc_o;
    s_pc4   = id_pc4_o;
    bundle  = {s_iv, s_instr, s_pc, s_pc4};
    chk("fetch_addr", s_addr, exp_fetch);
    if (prev_stall) chk("stall_hold", bundle, prev_bundle);
    if (prev_redir) chk("redirect_flush", s_iv, 1'b0);
    if (!s_iv) chk("idle_nop", s_instr, NOP_INSTR);

    imem_req_ready_i = rdy;
    id_ready_i       = idr;
    redirect_i       = redir;
    redirect_pc_i    = tgt;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = memq[0].addr ^ KEY;
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = $urandom;
    end

    fire = s_rv && rdy;
    if (fire) begin
      memq.push_back('{s_addr, cyc + lat});
      chk("inflight_bound", memq.size() <= DEPTH, 1'b1);
    end
    if (s_iv && idr && !redir) begin
      e4 = exp_pc + 32'd4;
      chk("id_pc", s_pc, exp_pc);
      chk("id_instr", s_instr, exp_pc ^ KEY);
      chk("id_pc4", s_pc4, e4);
      exp_pc = e4;
    end
    if (redir) begin
      exp_pc    = {tgt[31:2], 2'b00};
      exp_fetch = exp_pc;
    end else if (fire) begin
      exp_fetch = exp_fetch + 32'd4;
    end
    prev_redir  = redir;
    prev_stall  = s_iv && !idr && !redir;
    prev_bundle = bundle;
    cyc++;
  endtask

  // Raise rst between clock edges, check the immediate reset state, and
  // release it again with all inputs idle.
  task automatic do_reset();
    logic [31:0] rpc4;
    rpc4 = RESET_PC + 32'd4;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_req_valid", imem_req_valid_o, 1'b0);
    chk("rst_req_addr", imem_req_addr_o, RESET_PC);
    chk("rst_id_valid", id_valid_o, 1'b0);
    chk("rst_id_instr", id_instr_o, NOP_INSTR);
    chk("rst_id_pc", id_pc_o, RESET_PC);
    chk("rst_id_pc4", id_pc4_o, rpc4);
    imem_req_ready_i = 1'b0;
    id_ready_i       = 1'b0;
    redirect_i       = 1'b0;
    imem_rsp_valid_i = 1'b0;
    memq.delete();
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_pc     = RESET_PC;
    exp_fetch  = RESET_PC;
    prev_redir = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    step(1'b1, v.idr, 1'b0, 32'h0);
    chk({tag, "_req_valid"}, s_rv, v.rv);
    chk({tag, "_req_addr"}, s_addr, v.addr);
    chk({tag, "_id_valid"}, s_iv, v.iv);
    if (v.iv) chk({tag, "_id_pc"}, s_pc, v.pc);
  endtask

  initial begin
    bit          r, d, rd;
    logic [31:0] t;

    // 1-cycle memory, decode always ready: one instruction per cycle,
    // first decode-valid two cycles after the first request fire.
    stream_tbl[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    stream_tbl[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    stream_tbl[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    stream_tbl[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    stream_tbl[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    stream_tbl[5] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    // Decode stalled for 10 cycles: four fetches fill the credit, the head
    // holds pc 0, then the backlog drains in order.
    stall_tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    stall_tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    stall_tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
    stall_tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
    for (int i = 4; i < 10; i++) stall_tbl[i] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    stall_tbl[10] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
    stall_tbl[11] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
    stall_tbl[12] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    stall_tbl[13] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    stall_tbl[14] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    stall_tbl[15] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    id_ready_i       = 1'b0;
    exp_pc           = RESET_PC;
    exp_fetch        = RESET_PC;
    prev_redir       = 1'b0;
    prev_stall       = 1'b0;
    prev_bundle      = '0;

    // Reset and steady stream
    do_reset();
    lat = 1;
    foreach (stream_tbl[i]) run_vec(stream_tbl[i], "stream");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset in the middle of the stream
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("post_rst_req_valid", s_rv, 1'b1);
    chk("post_rst_req_addr", s_addr, RESET_PC);

    // Stall timeline from a fresh reset
    do_reset();
    foreach (stall_tbl[i]) run_vec(stall_tbl[i], "stall");

    // Redirect with two requests in flight and a third firing that cycle
    do_reset();
    lat = 3;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    chk("inflight_at_redirect", memq.size(), 3);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redirect_target_addr", s_addr, 32'h0000_0100);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stale_dropped_idle", s_iv, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("first_target_valid", s_iv, 1'b1);
    chk("first_target_pc", s_pc, 32'h0000_0100);

    // Redirect coinciding with a response and a decode pop
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    chk("coincide_pop_offered", s_iv, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("coincide_flush", s_iv, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("coincide_stale_dropped", s_iv, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("coincide_target_valid", s_iv, 1'b1);
    chk("coincide_target_pc", s_pc, 32'h0000_0200);

    // Address wrap at the top of memory
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr_zero", s_addr, 32'h0000_0000);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_id_valid", s_iv, 1'b1);
    chk("wrap_id_pc", s_pc, 32'hFFFF_FFFC);
    chk("wrap_id_pc4", s_pc4, 32'h0000_0000);

    // Randomized traffic checked against the program-order model
    for (int seg = 0; seg < 40; seg++) begin
      lat = $urandom_range(1, 4);
      for (int i = 0; i < 50; i++) begin
        r  = ($urandom_range(0, 3) != 0);
        d  = ($urandom_range(0, 9) < 7);
        rd = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else t = $urandom;
        step(r, d, rd, t);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
